id_scoreboard_decoder: RTL and testbench

ID_SCOREBOARD_DECODER -- requirements
Module: id_scoreboard_decoder

---
 rtl/id_scoreboard_decoder_pkg.sv | 22 ++
 rtl/id_scoreboard.sv | 51 +++++
 rtl/id_scoreboard_decoder.sv | 158 +++++++++++++++
 tb/tb_id_scoreboard_decoder.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_scoreboard_decoder_pkg.sv
// Shared widths and immediate-extension helpers for the decode/scoreboard stage.
// Helpers work on a fixed 64-bit carrier; callers cast to their own widths.
package id_scoreboard_decoder_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_NREG   = 32;
   localparam int DEF_IMM_W  = 16;
   localparam int DEF_CNT_W  = 16;
   localparam int EXT_W      = 64;

   // Sign-extends the low w bits of v to EXT_W bits.
   function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] v, input int w);
      logic signed [EXT_W-1:0] t;
      t = v << (EXT_W - w);
      return t >>> (EXT_W - w);
   endfunction

   function automatic logic [EXT_W-1:0] sext_sl2(input logic [EXT_W-1:0] v, input int w);
      return sext(v, w) << 2;
   endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy-bit scoreboard: one bit per register, register 0 never busy.
// Set wins over both clears; queries ignore a bit that writeback clears this cycle.
module id_scoreboard #(
   parameter int NREG   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              set_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              wb_clr_i,
   input  logic [ADDR_W-1:0] wb_clr_addr_i,
   input  logic              fl_clr_i,
   input  logic [ADDR_W-1:0] fl_clr_addr_i,
   input  logic [ADDR_W-1:0] q_rs_addr_i,
   input  logic [ADDR_W-1:0] q_rt_addr_i,
   input  logic [ADDR_W-1:0] q_dst_addr_i,
   output logic              busy_rs_o,
   output logic              busy_rt_o,
   output logic              busy_dst_o,
   output logic [NREG-1:0]   busy_o
);

   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] wb_mask;
   logic [NREG-1:0] busy_eff;

   always_comb begin
      busy_d  = busy_q;
      wb_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         wb_mask[i] = wb_clr_i && (wb_clr_addr_i == ADDR_W'(i));
         if (wb_mask[i]) busy_d[i] = 1'b0;
         if (fl_clr_i && (fl_clr_addr_i == ADDR_W'(i))) busy_d[i] = 1'b0;
         if (set_i && (set_addr_i == ADDR_W'(i))) busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   assign busy_eff   = busy_q & ~wb_mask;
   assign busy_rs_o  = busy_eff[q_rs_addr_i];
   assign busy_rt_o  = busy_eff[q_rt_addr_i];
   assign busy_dst_o = busy_eff[q_dst_addr_i];
   assign busy_o     = busy_q;

endmodule

// File: rtl/id_scoreboard_decoder.sv
// Decode stage: operand fetch with writeback bypass, immediate extension,
// RAW/WAW hazard stall against a busy-bit scoreboard, one-entry output register.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// valid never depends on ready, and a held output stays stable until taken or flushed.
module id_scoreboard_decoder
   import id_scoreboard_decoder_pkg::*;
#(
   parameter int   DATA_W = DEF_DATA_W,
   parameter int   NREG   = DEF_NREG,
   parameter int   IMM_W  = DEF_IMM_W,
   parameter int   CNT_W  = DEF_CNT_W,
   localparam int  ADDR_W = $clog2(NREG)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [ADDR_W-1:0] rs_i,
   input  logic [ADDR_W-1:0] rt_i,
   input  logic [ADDR_W-1:0] rd_i,
   input  logic [IMM_W-1:0]  imm_i,
   input  logic              uses_rt_i,
   input  logic              reg_dst_i,
   input  logic              reg_write_cu_i,
   output logic [ADDR_W-1:0] rf_addr1_o,
   output logic [ADDR_W-1:0] rf_addr2_o,
   input  logic [DATA_W-1:0] rf_data1_i,
   input  logic [DATA_W-1:0] rf_data2_i,
   input  logic              wb_valid_i,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data1_o,
   output logic [DATA_W-1:0] out_data2_o,
   output logic [IMM_W-1:0]  out_imm_raw_o,
   output logic [DATA_W-1:0] out_imm_sext_o,
   output logic [DATA_W-1:0] out_imm_sext_sl2_o,
   output logic [ADDR_W-1:0] out_dest_o,
   output logic              out_we_o,
   output logic              hazard_stall_o,
   output logic [CNT_W-1:0]  stall_cycles_o,
   output logic [NREG-1:0]   busy_o
);

   logic [ADDR_W-1:0] dest;
   logic              we, hazard, accept, wb_live;
   logic              busy_rs, busy_rt, busy_dst;
   logic [DATA_W-1:0] op1, op2;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
   logic [IMM_W-1:0]  imm_q, imm_d;
   logic [DATA_W-1:0] sext_q, sext_d, sl2_q, sl2_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic              we_q, we_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   assign dest    = reg_dst_i ? rd_i : rt_i;
   assign we      = reg_write_cu_i && (dest != '0);
   assign wb_live = wb_valid_i && (wb_addr_i != '0);

   id_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W)) u_sb (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .set_i         (accept && we),
      .set_addr_i    (dest),
      .wb_clr_i      (wb_live),
      .wb_clr_addr_i (wb_addr_i),
      .fl_clr_i      (flush_i && out_valid_q && we_q),
      .fl_clr_addr_i (dest_q),
      .q_rs_addr_i   (rs_i),
      .q_rt_addr_i   (rt_i),
      .q_dst_addr_i  (dest),
      .busy_rs_o     (busy_rs),
      .busy_rt_o     (busy_rt),
      .busy_dst_o    (busy_dst),
      .busy_o        (busy_o)
   );

   assign hazard         = busy_rs || (uses_rt_i && busy_rt) || (we && busy_dst);
   assign in_ready_o     = !hazard && (!out_valid_q || out_ready_i) && !flush_i;
   assign accept         = in_valid_i && in_ready_o;
   assign hazard_stall_o = in_valid_i && hazard;

   assign rf_addr1_o = rs_i;
   assign rf_addr2_o = rt_i;

   // Register 0 reads as zero even when a writeback targets it.
   assign op1 = (rs_i == '0) ? '0 : (wb_live && wb_addr_i == rs_i) ? wb_data_i : rf_data1_i;
   assign op2 = (rt_i == '0) ? '0 : (wb_live && wb_addr_i == rt_i) ? wb_data_i : rf_data2_i;

   always_comb begin
      out_valid_d = out_valid_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      imm_d       = imm_q;
      sext_d      = sext_q;
      sl2_d       = sl2_q;
      dest_d      = dest_q;
      we_d        = we_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         data1_d     = op1;
         data2_d     = op2;
         imm_d       = imm_i;
         sext_d      = DATA_W'(sext(EXT_W'(imm_i), IMM_W));
         sl2_d       = DATA_W'(sext_sl2(EXT_W'(imm_i), IMM_W));
         dest_d      = dest;
         we_d        = we;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (hazard_stall_o && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         data1_q     <= '0;
         data2_q     <= '0;
         imm_q       <= '0;
         sext_q      <= '0;
         sl2_q       <= '0;
         dest_q      <= '0;
         we_q        <= 1'b0;
         stall_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         imm_q       <= imm_d;
         sext_q      <= sext_d;
         sl2_q       <= sl2_d;
         dest_q      <= dest_d;
         we_q        <= we_d;
         stall_q     <= stall_d;
      end
   end

   assign out_valid_o        = out_valid_q;
   assign out_data1_o        = data1_q;
   assign out_data2_o        = data2_q;
   assign out_imm_raw_o      = imm_q;
   assign out_imm_sext_o     = sext_q;
   assign out_imm_sext_sl2_o = sl2_q;
   assign out_dest_o         = dest_q;
   assign out_we_o           = we_q;
   assign stall_cycles_o     = stall_q;

endmodule

// File: tb/tb_id_scoreboard_decoder.sv
// Bench for id_scoreboard_decoder: register-file model, expected-output queue,
// one task per scenario. A small CNT_W makes counter saturation reachable.
module tb_id_scoreboard_decoder;

   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int IMM_W  = 16;
   localparam int CNT_W  = 4;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [15:0] imm;
      logic [31:0] sext;
      logic [31:0] sl2;
      logic [4:0]  dest;
      logic        we;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0, in_ready;
   logic [ADDR_W-1:0] rs = '0, rt = '0, rd = '0;
   logic [IMM_W-1:0]  imm = '0;
   logic uses_rt = 1'b0, reg_dst = 1'b0, reg_write_cu = 1'b0;
   logic [ADDR_W-1:0] rf_addr1, rf_addr2;
   logic [DATA_W-1:0] rf_data1, rf_data2;
   logic wb_valid = 1'b0;
   logic [ADDR_W-1:0] wb_addr = '0;
   logic [DATA_W-1:0] wb_data = '0;
   logic flush = 1'b0;
   logic out_valid, out_ready = 1'b1;
   logic [DATA_W-1:0] out_data1, out_data2, out_imm_sext, out_imm_sext_sl2;
   logic [IMM_W-1:0]  out_imm_raw;
   logic [ADDR_W-1:0] out_dest;
   logic out_we, hazard_stall;
   logic [CNT_W-1:0] stall_cycles;
   logic [NREG-1:0] busy;

   logic [DATA_W-1:0] rf_model [NREG];
   exp_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int stall_exp = 0;

   assign rf_data1 = rf_model[rf_addr1];
   assign rf_data2 = rf_model[rf_addr2];

   id_scoreboard_decoder #(.DATA_W(DATA_W), .NREG(NREG), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm),
      .uses_rt_i(uses_rt), .reg_dst_i(reg_dst), .reg_write_cu_i(reg_write_cu),
      .rf_addr1_o(rf_addr1), .rf_addr2_o(rf_addr2),
      .rf_data1_i(rf_data1), .rf_data2_i(rf_data2),
      .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data1_o(out_data1), .out_data2_o(out_data2),
      .out_imm_raw_o(out_imm_raw), .out_imm_sext_o(out_imm_sext),
      .out_imm_sext_sl2_o(out_imm_sext_sl2),
      .out_dest_o(out_dest), .out_we_o(out_we),
      .hazard_stall_o(hazard_stall), .stall_cycles_o(stall_cycles),
      .busy_o(busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic logic [31:0] src_val(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_valid && wb_addr == a) return wb_data;
      return rf_model[a];
   endfunction

   function automatic exp_t model_now();
      exp_t e;
      e.dest = reg_dst ? rd : rt;
      e.we   = reg_write_cu && (e.dest != 5'd0);
      e.d1   = src_val(rs);
      e.d2   = src_val(rt);
      e.imm  = imm;
      e.sext = {{16{imm[15]}}, imm};
      e.sl2  = {e.sext[29:0], 2'b00};
      return e;
   endfunction

   function automatic void bump_stall();
      stall_exp = (stall_exp == 15) ? 15 : stall_exp + 1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      logic w;
      logic [4:0] a;
      logic [31:0] d;
      w = wb_valid && (wb_addr != 5'd0);
      a = wb_addr;
      d = wb_data;
      @(posedge clk);
      #1;
      if (w) rf_model[a] = d;
   endtask

   task automatic drive(input logic [4:0] a_rs, a_rt, a_rd, input logic [15:0] a_imm,
                        input logic a_urt, a_rdst, a_wcu);
      in_valid = 1'b1; rs = a_rs; rt = a_rt; rd = a_rd; imm = a_imm;
      uses_rt = a_urt; reg_dst = a_rdst; reg_write_cu = a_wcu;
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      #1;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         exp_t e;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output got d1=%h dest=%0d, no transfer expected", out_data1, out_dest);
         end else begin
            e = exp_q.pop_front();
            if ({out_data1, out_data2, out_imm_raw, out_imm_sext, out_imm_sext_sl2, out_dest, out_we} !== e) begin
               miscompares++;
               $display("FAIL out_txn got d1=%h d2=%h imm=%h sx=%h sl2=%h dest=%0d we=%b exp d1=%h d2=%h imm=%h sx=%h sl2=%h dest=%0d we=%b",
                        out_data1, out_data2, out_imm_raw, out_imm_sext, out_imm_sext_sl2, out_dest, out_we,
                        e.d1, e.d2, e.imm, e.sext, e.sl2, e.dest, e.we);
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== '0 || stall_cycles !== '0) begin
         miscompares++;
         $display("FAIL reset_state out_valid=%b busy=%h stall=%0d exp 0/0/0", out_valid, busy, stall_cycles);
      end
      vectors++;
      if ({out_data1, out_data2, out_imm_raw, out_imm_sext, out_imm_sext_sl2, out_dest, out_we} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs d1=%h d2=%h imm=%h dest=%0d exp all 0", out_data1, out_data2, out_imm_raw, out_dest);
      end
      vectors++;
      if (in_ready !== 1'b1 || hazard_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready in_ready=%b hazard=%b exp 1/0", in_ready, hazard_stall);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
               16'($urandom_range(0, 16'hFFFF)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         vectors++;
         if (in_ready !== 1'b1 || hazard_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready[%0d] in_ready=%b hazard=%b exp 1/0", i, in_ready, hazard_stall);
         end
         exp_q.push_back(model_now());
         step();
      end
      idle();
      step();
   endtask

   task automatic test_imm();
      drive(5'd0, 5'd0, 5'd0, 16'h8000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(model_now());
      step();
      idle();
      vectors++;
      if (out_imm_raw !== 16'h8000 || out_imm_sext !== 32'hFFFF8000 || out_imm_sext_sl2 !== 32'hFFFE0000) begin
         miscompares++;
         $display("FAIL imm_8000 raw=%h sx=%h sl2=%h exp 8000/ffff8000/fffe0000", out_imm_raw, out_imm_sext, out_imm_sext_sl2);
      end
      drive(5'd3, 5'd4, 5'd0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(model_now());
      step();
      idle();
      vectors++;
      if (out_imm_sext !== 32'h00007FFF || out_imm_sext_sl2 !== 32'h0001FFFC) begin
         miscompares++;
         $display("FAIL imm_7fff sx=%h sl2=%h exp 00007fff/0001fffc", out_imm_sext, out_imm_sext_sl2);
      end
      step();
   endtask

   task automatic test_raw();
      drive(5'd1, 5'd5, 5'd0, 16'h0007, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(model_now());
      step();
      drive(5'd5, 5'd2, 5'd6, 16'h0010, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_stall[%0d] hazard=%b in_ready=%b exp 1/0", c, hazard_stall, in_ready);
         end
         bump_stall();
         step();
      end
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE0005;
      #1;
      vectors++;
      if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL raw_release hazard=%b in_ready=%b exp 0/1", hazard_stall, in_ready);
      end
      exp_q.push_back(model_now());
      step();
      wb_valid = 1'b0;
      idle();
      vectors++;
      if (out_data1 !== 32'hCAFE0005 || busy[6:5] !== 2'b10) begin
         miscompares++;
         $display("FAIL raw_bypass d1=%h busy[6:5]=%b exp cafe0005/10", out_data1, busy[6:5]);
      end
      wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h00000666;
      step();
      wb_valid = 1'b0;
      #1;
      vectors++;
      if (stall_cycles !== 4'(stall_exp) || busy !== '0) begin
         miscompares++;
         $display("FAIL raw_count stall=%0d busy=%h exp %0d/0", stall_cycles, busy, stall_exp);
      end
   endtask

   task automatic test_waw();
      drive(5'd0, 5'd0, 5'd7, 16'h0001, 1'b0, 1'b1, 1'b1);
      exp_q.push_back(model_now());
      step();
      drive(5'd0, 5'd0, 5'd7, 16'h0002, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
         vectors++;
         if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_stall[%0d] hazard=%b in_ready=%b exp 1/0", c, hazard_stall, in_ready);
         end
         bump_stall();
         step();
      end
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77777777;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL waw_release in_ready=%b exp 1", in_ready);
      end
      exp_q.push_back(model_now());
      step();
      idle();
      vectors++;
      if (busy[7] !== 1'b1 || stall_cycles !== 4'(stall_exp)) begin
         miscompares++;
         $display("FAIL waw_set_wins busy7=%b stall=%0d exp 1/%0d", busy[7], stall_cycles, stall_exp);
      end
      wb_data = 32'h77770002;
      step();
      wb_valid = 1'b0;
      #1;
   endtask

   task automatic test_backpressure();
      exp_t a;
      out_ready = 1'b0;
      drive(5'd3, 5'd4, 5'd0, 16'h00AA, 1'b1, 1'b0, 1'b0);
      a = model_now();
      exp_q.push_back(a);
      step();
      drive(5'd8, 5'd9, 5'd0, 16'h00BB, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || hazard_stall !== 1'b0 ||
             out_imm_raw !== a.imm || out_data1 !== a.d1 || out_data2 !== a.d2) begin
            miscompares++;
            $display("FAIL bp_hold[%0d] ov=%b rdy=%b hz=%b imm=%h d1=%h exp 1/0/0/%h/%h",
                     c, out_valid, in_ready, hazard_stall, out_imm_raw, out_data1, a.imm, a.d1);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release in_ready=%b exp 1", in_ready);
      end
      exp_q.push_back(model_now());
      step();
      idle();
      vectors++;
      if (out_valid !== 1'b1 || out_imm_raw !== 16'h00BB) begin
         miscompares++;
         $display("FAIL bp_next ov=%b imm=%h exp 1/00bb", out_valid, out_imm_raw);
      end
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(5'd0, 5'd9, 5'd0, 16'h0009, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(model_now());
      step();
      idle();
      flush = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || busy[9] !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_cycle in_ready=%b busy9=%b exp 0/1", in_ready, busy[9]);
      end
      void'(exp_q.pop_back());
      step();
      flush = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_done out_valid=%b busy9=%b exp 0/0", out_valid, busy[9]);
      end
      out_ready = 1'b1;
      drive(5'd9, 5'd0, 5'd0, 16'h0019, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_reader hazard=%b in_ready=%b exp 0/1", hazard_stall, in_ready);
      end
      exp_q.push_back(model_now());
      step();
      idle();
      step();
   endtask

   task automatic test_r0();
      drive(5'd0, 5'd0, 5'd0, 16'h0F00, 1'b0, 1'b1, 1'b1);
      exp_q.push_back(model_now());
      step();
      idle();
      vectors++;
      if (busy !== '0 || out_we !== 1'b0) begin
         miscompares++;
         $display("FAIL r0_writer busy=%h we=%b exp 0/0", busy, out_we);
      end
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
      drive(5'd0, 5'd0, 5'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL r0_reader hazard=%b in_ready=%b exp 0/1", hazard_stall, in_ready);
      end
      exp_q.push_back(model_now());
      step();
      wb_valid = 1'b0;
      idle();
      vectors++;
      if (out_data1 !== 32'd0 || out_data2 !== 32'd0 || busy !== '0) begin
         miscompares++;
         $display("FAIL r0_data d1=%h d2=%h busy=%h exp 0/0/0", out_data1, out_data2, busy);
      end
      step();
   endtask

   task automatic test_saturation();
      drive(5'd0, 5'd0, 5'd12, 16'h000C, 1'b0, 1'b1, 1'b1);
      exp_q.push_back(model_now());
      step();
      drive(5'd12, 5'd0, 5'd0, 16'h00C0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 14; c++) begin
         vectors++;
         if (hazard_stall !== 1'b1 || stall_cycles !== 4'(stall_exp)) begin
            miscompares++;
            $display("FAIL sat_count[%0d] hazard=%b stall=%0d exp 1/%0d", c, hazard_stall, stall_cycles, stall_exp);
         end
         bump_stall();
         step();
      end
      wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000C0DE;
      #1;
      exp_q.push_back(model_now());
      step();
      wb_valid = 1'b0;
      idle();
      vectors++;
      if (stall_cycles !== 4'd15 || stall_exp != 15) begin
         miscompares++;
         $display("FAIL sat_final stall=%0d exp 15", stall_cycles);
      end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(5'd0, 5'd0, 5'd3, 16'h0033, 1'b0, 1'b1, 1'b1);
      step();
      idle();
      vectors++;
      if (out_valid !== 1'b1 || busy[3] !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_loaded out_valid=%b busy3=%b exp 1/1", out_valid, busy[3]);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== '0 || stall_cycles !== '0 ||
          {out_data1, out_data2, out_imm_raw, out_imm_sext, out_imm_sext_sl2, out_dest, out_we} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset ov=%b busy=%h stall=%0d imm=%h dest=%0d exp all 0",
                  out_valid, busy, stall_cycles, out_imm_raw, out_dest);
      end
      stall_exp = 0;
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_after out_valid=%b exp 0", out_valid);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      for (int i = 0; i < NREG; i++) rf_model[i] = $urandom;
      rf_model[0] = 32'hDEADBEEF;
      test_reset();
      test_back_to_back();
      test_imm();
      test_raw();
      test_waw();
      test_backpressure();
      test_flush();
      test_r0();
      test_saturation();
      test_reset_mid();
      step();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
